// File: rtl/smac_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// smac_ctrl_pkg
// Shared types and constants for the bit-serial weight MAC (SMAC) control.
//   wser_state_t  : control FSM state encoding
//   CYC_PER_SLICE : clock cycles spent per weight bit-slice (STEP, WAIT, EVAL)
// ---------------------------------------------------------------------------
package smac_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        STEP = 3'd2,
        WAIT = 3'd3,
        EVAL = 3'd4,
        OUT  = 3'd5
    } wser_state_t;

    localparam int CYC_PER_SLICE = 3;

endpackage

// File: rtl/ctrl_fsm_wser.sv
// ---------------------------------------------------------------------------
// ctrl_fsm_wser
// Control FSM for the bit-serial weight MAC datapath. Accepts one job per
// w_vld/w_rdy handshake, walks the peer weight-bit counter through Pw slices
// (STEP -> WAIT -> EVAL each), subtracts on the MSB slice and presents the
// result with an out_vld/out_rdy handshake.
//
// Parameter
//   Pw        weight precision in bits (>= 3), equal to the peer counter's Pw
// Ports
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   w_vld     in : job available upstream
//   w_rdy     out: job accepted (high only in IDLE)
//   flush     in : abort current job (ignored in IDLE)
//   bit_1     in : counter flag, exactly one slice done
//   bit_m     in : counter flag, Pw-1 slices done (next slice is the MSB)
//   w_cnt     out: counter increment pulse
//   cnt_clear out: counter clear
//   w_load    out: sample weight/activation registers
//   acc_clr   out: clear the accumulator
//   acc_en    out: accumulate the current partial product
//   msb_sub   out: subtract this slice (two's-complement MSB)
//   out_vld   out: result valid
//   out_rdy   in : downstream accepts the result
//   busy      out: any state other than IDLE
//   flag_err  out: sticky counter-flag consistency error
//                  (only when CTRL_WSER_FLAGCHK_EN is defined)
//
// Build option CTRL_WSER_FLAGCHK_EN adds the flag_err port and a slice
// counter that cross-checks bit_1/bit_m against the expected slice number.
// ---------------------------------------------------------------------------
module ctrl_fsm_wser
    import smac_ctrl_pkg::*;
#(
    parameter int Pw = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic w_vld,
    output logic w_rdy,
    input  logic flush,
    input  logic bit_1,
    input  logic bit_m,
    output logic w_cnt,
    output logic cnt_clear,
    output logic w_load,
    output logic acc_clr,
    output logic acc_en,
    output logic msb_sub,
    output logic out_vld,
    input  logic out_rdy,
    output logic busy
`ifdef CTRL_WSER_FLAGCHK_EN
    ,
    output logic flag_err
`endif
);

    wser_state_t state_r;
    wser_state_t next_state_s;
    logic        msb_pend_r;
    logic        msb_pend_set_s;
    logic        flush_clr_r;
    logic        flush_take_s;

    // State register plus the one-cycle counter-clear marker left by a flush
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            flush_clr_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            flush_clr_r <= flush_take_s;
        end
    end

    // MSB-pending flag: armed when bit_m is seen at EVAL, so the next STEP subtracts
    always_ff @(posedge clk) begin
        if (rst) begin
            msb_pend_r <= 1'b0;
        end else if (state_r == LOAD) begin
            msb_pend_r <= 1'b0;
        end else if (msb_pend_set_s) begin
            msb_pend_r <= 1'b1;
        end else begin
            msb_pend_r <= msb_pend_r;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        next_state_s   = state_r;
        flush_take_s   = 1'b0;
        msb_pend_set_s = 1'b0;
        w_rdy          = 1'b0;
        w_cnt          = 1'b0;
        cnt_clear      = flush_clr_r;
        w_load         = 1'b0;
        acc_clr        = 1'b0;
        acc_en         = 1'b0;
        msb_sub        = 1'b0;
        out_vld        = 1'b0;
        busy           = 1'b1;

        case (state_r)
            IDLE: begin
                w_rdy = 1'b1;
                busy  = 1'b0;
                if (w_vld) begin
                    next_state_s = LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                w_load       = 1'b1;
                cnt_clear    = 1'b1;
                acc_clr      = 1'b1;
                next_state_s = STEP;
            end
            STEP: begin
                w_cnt        = 1'b1;
                acc_en       = 1'b1;
                msb_sub      = msb_pend_r;
                next_state_s = WAIT;
            end
            WAIT: begin
                // Gives the counter's registered flags time to reflect this slice
                next_state_s = EVAL;
            end
            EVAL: begin
                if (msb_pend_r) begin
                    next_state_s = OUT;
                end else if (bit_m) begin
                    msb_pend_set_s = 1'b1;
                    next_state_s   = STEP;
                end else begin
                    next_state_s = STEP;
                end
            end
            OUT: begin
                out_vld = 1'b1;
                if (out_rdy) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = OUT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase

        // Abort overrides every transition outside IDLE
        if (flush && (state_r != IDLE)) begin
            next_state_s   = IDLE;
            flush_take_s   = 1'b1;
            msb_pend_set_s = 1'b0;
        end else begin
            flush_take_s = 1'b0;
        end
    end

`ifdef CTRL_WSER_FLAGCHK_EN
    localparam int SW = $clog2(Pw) + 1;

    logic [SW-1:0] slice_r;
    logic          flag_err_r;
    logic          chk_bad_s;

    // Slices issued in the current job; saturates so a runaway job cannot alias
    always_ff @(posedge clk) begin
        if (rst) begin
            slice_r <= {SW{1'b0}};
        end else if (state_r == LOAD) begin
            slice_r <= {SW{1'b0}};
        end else if ((state_r == STEP) && (slice_r != {SW{1'b1}})) begin
            slice_r <= slice_r + SW'(1);
        end else begin
            slice_r <= slice_r;
        end
    end

    // Flag consistency at EVAL: bit_1 after slice 1, bit_m only after slice Pw-1
    always_comb begin
        chk_bad_s = 1'b0;
        if (state_r == EVAL) begin
            if (slice_r == SW'(Pw - 1)) begin
                chk_bad_s = ~bit_m;
            end else begin
                chk_bad_s = bit_m | ((slice_r == SW'(1)) & ~bit_1);
            end
        end else begin
            chk_bad_s = 1'b0;
        end
    end

    // Sticky error, cleared by reset or the next job's LOAD
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_err_r <= 1'b0;
        end else if (state_r == LOAD) begin
            flag_err_r <= 1'b0;
        end else if (chk_bad_s) begin
            flag_err_r <= 1'b1;
        end else begin
            flag_err_r <= flag_err_r;
        end
    end

    assign flag_err = flag_err_r;
`else
    // bit_1 only feeds the flag checker; without it the flag is intentionally unused
    logic bit_1_unused_s;
    assign bit_1_unused_s = bit_1;
`endif

endmodule
